// File: rtl/mfcc_framer_if.sv
// Sample stream bundle for the MFCC frame scheduler.
// Upstream s_* accepts samples, downstream m_* carries framed samples.
interface mfcc_framer_if #(
    parameter int DATA_W = 16
);
    logic              s_valid;
    logic              s_ready;
    logic [DATA_W-1:0] s_data;
    logic              m_valid;
    logic              m_ready;
    logic [DATA_W-1:0] m_data;
    logic              m_first;
    logic              m_last;

    modport master (
        output s_valid, s_data, m_ready,
        input  s_ready, m_valid, m_data, m_first, m_last
    );

    modport slave (
        input  s_valid, s_data, m_ready,
        output s_ready, m_valid, m_data, m_first, m_last
    );
endinterface

// File: rtl/mfcc_framer.sv
// Ring-buffered frame scheduler: emits overlapping FRAME_LEN-sample
// frames advancing HOP samples, with upstream back-pressure.
module mfcc_framer #(
    parameter int DATA_W    = 16,
    parameter int FRAME_LEN = 400,
    parameter int HOP       = 160,
    parameter int BUF_DEPTH = 512
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        clear,
    mfcc_framer_if.slave bus,
    output logic [15:0] frame_cnt
);
    localparam int AW = $clog2(BUF_DEPTH);
    localparam int CW = AW + 1;
    localparam int IW = $clog2(FRAME_LEN + 1);

    localparam logic [CW-1:0] DEPTH_C = CW'(BUF_DEPTH);
    localparam logic [CW-1:0] FL_C    = CW'(FRAME_LEN);
    localparam logic [CW-1:0] HOP_C   = CW'(HOP);
    localparam logic [AW-1:0] HOP_A   = AW'(HOP);
    localparam logic [IW-1:0] FL_I    = IW'(FRAME_LEN);
    localparam logic [IW-1:0] FLM1_I  = IW'(FRAME_LEN - 1);

    typedef enum logic {
        IDLE = 1'b0,
        EMIT = 1'b1
    } state_t;

    state_t state_q, state_d;

    logic [DATA_W-1:0] mem [BUF_DEPTH];

    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     base;
    logic [CW-1:0]     count;
    logic [IW-1:0]     rd_idx;
    logic [AW-1:0]     rd_addr;

    logic [DATA_W-1:0] m_data_q;
    logic              m_valid_q;
    logic              m_first_q;
    logic              m_last_q;

    logic              s_ready_w;
    logic              s_hs;
    logic              m_hs;
    logic              last_hs;
    logic              load;

    assign s_ready_w = rst_n & ~clear & (count < DEPTH_C);
    assign s_hs      = bus.s_valid & s_ready_w;
    assign m_hs      = m_valid_q & bus.m_ready;
    assign last_hs   = m_hs & m_last_q;
    assign rd_addr   = base + AW'(rd_idx);

    assign bus.s_ready = s_ready_w;
    assign bus.m_valid = m_valid_q;
    assign bus.m_data  = m_data_q;
    assign bus.m_first = m_first_q;
    assign bus.m_last  = m_last_q;

    // rd_idx counts reads issued, so the read runs one beat ahead of the handshake
    always_comb begin
        state_d = state_q;
        load    = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (count >= FL_C) state_d = EMIT;
            end
            EMIT: begin
                load = (~m_valid_q | bus.m_ready) & (rd_idx != FL_I);
                if (last_hs) state_d = IDLE;
            end
        endcase
        if (clear) begin
            state_d = IDLE;
            load    = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_ff @(posedge clk) begin
        if (s_hs) mem[wr_ptr] <= bus.s_data;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr    <= '0;
            base      <= '0;
            count     <= '0;
            rd_idx    <= '0;
            frame_cnt <= '0;
            m_data_q  <= '0;
            m_valid_q <= 1'b0;
            m_first_q <= 1'b0;
            m_last_q  <= 1'b0;
        end else begin
            if (s_hs) wr_ptr <= wr_ptr + AW'(1);
            if (clear) begin
                base      <= wr_ptr;
                count     <= '0;
                rd_idx    <= '0;
                frame_cnt <= '0;
                m_valid_q <= 1'b0;
                m_first_q <= 1'b0;
                m_last_q  <= 1'b0;
            end else begin
                count <= count + CW'(s_hs) - (last_hs ? HOP_C : '0);
                if (last_hs) begin
                    base      <= base + HOP_A;
                    rd_idx    <= '0;
                    frame_cnt <= frame_cnt + 16'd1;
                end
                if (load) begin
                    m_data_q  <= mem[rd_addr];
                    m_first_q <= (rd_idx == '0);
                    m_last_q  <= (rd_idx == FLM1_I);
                    m_valid_q <= 1'b1;
                    rd_idx    <= rd_idx + IW'(1);
                end else if (m_hs) begin
                    m_valid_q <= 1'b0;
                end
            end
        end
    end
endmodule

// File: tb/tb_mfcc_framer.sv
// Directed bench for mfcc_framer: small 8/4/16 instance for the
// framing corner cases plus a default-parameter instance for the ramp.
module tb_mfcc_framer;
    typedef struct {
        logic [15:0] data;
        logic        first;
        logic        last;
    } beat_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        clear = 1'b0;
    logic        clear2 = 1'b0;
    logic [15:0] frame_cnt;
    logic [15:0] frame_cnt2;

    mfcc_framer_if #(.DATA_W(16)) bus ();
    mfcc_framer_if #(.DATA_W(16)) bus2 ();

    mfcc_framer #(
        .DATA_W(16), .FRAME_LEN(8), .HOP(4), .BUF_DEPTH(16)
    ) dut (
        .clk(clk), .rst_n(rst_n), .clear(clear),
        .bus(bus), .frame_cnt(frame_cnt)
    );

    mfcc_framer dut2 (
        .clk(clk), .rst_n(rst_n), .clear(clear2),
        .bus(bus2), .frame_cnt(frame_cnt2)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int failed = 0;
    int cyc = 0;
    int pv = 100;
    int pr = 100;
    int cnt_m = 0;
    bit over = 1'b0;
    int last_acc_cyc = -1;
    int first_v_cyc = -1;

    logic [15:0] src_q[$];
    logic [15:0] acc_q[$];
    logic [17:0] cap_q[$];
    int          cap_cyc[$];

    beat_t tab1[32];
    int    starts1[4] = '{0, 4, 8, 12};

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic flush_q();
        src_q.delete();
        acc_q.delete();
        cap_q.delete();
        cap_cyc.delete();
        cnt_m = 0;
        first_v_cyc = -1;
    endtask

    task automatic cycle();
        bus.s_valid = (src_q.size() > 0) && ($urandom_range(99) < pv);
        bus.s_data  = (src_q.size() > 0) ? src_q[0] : 16'h0;
        bus.m_ready = ($urandom_range(99) < pr);
        @(negedge clk);
        if (bus.s_valid && bus.s_ready) begin
            acc_q.push_back(src_q.pop_front());
            cnt_m++;
            last_acc_cyc = cyc + 1;
        end
        if (bus.m_valid && first_v_cyc < 0) first_v_cyc = cyc;
        if (bus.m_valid && bus.m_ready) begin
            cap_q.push_back({bus.m_data, bus.m_first, bus.m_last});
            cap_cyc.push_back(cyc);
            if (bus.m_last) cnt_m -= 4;
        end
        if (cnt_m > 16) over = 1'b1;
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) cycle();
    endtask

    task automatic do_clear();
        pv = 0;
        pr = 0;
        clear = 1'b1;
        cycle();
        clear = 1'b0;
        flush_q();
    endtask

    task automatic check_model(input string nm);
        int n;
        int nf;
        n  = acc_q.size();
        nf = (n >= 8) ? (n - 8) / 4 + 1 : 0;
        chk({nm, " beats"}, cap_q.size(), nf * 8);
        for (int f = 0; f < nf; f++) begin
            for (int j = 0; j < 8; j++) begin
                if (f * 8 + j < cap_q.size())
                    chk($sformatf("%s f%0d b%0d", nm, f, j),
                        cap_q[f*8+j],
                        {acc_q[f*4+j], j == 0, j == 7});
            end
        end
    endtask

    initial begin
        int fi;
        int st;
        int off;
        int bad2;
        int done2;
        int n2;
        int tail;
        logic [15:0] v;

        for (int f = 0; f < 4; f++)
            for (int j = 0; j < 8; j++)
                tab1[f*8+j] = '{16'(starts1[f] + j), j == 0, j == 7};

        bus.s_valid = 1'b0;
        bus.s_data = '0;
        bus.m_ready = 1'b0;
        bus2.s_valid = 1'b0;
        bus2.s_data = '0;
        bus2.m_ready = 1'b0;

        // reset state
        #12;
        chk("rst s_ready", bus.s_ready, 0);
        chk("rst m_valid", bus.m_valid, 0);
        chk("rst frame_cnt", frame_cnt, 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // 1: 0..19, m_ready=1, table-driven
        flush_q();
        for (int i = 0; i < 20; i++) src_q.push_back(16'(i));
        pv = 100;
        pr = 100;
        run(80);
        chk("t1 beats", cap_q.size(), 32);
        for (int i = 0; i < 32; i++) begin
            if (i < cap_q.size())
                chk($sformatf("t1 beat %0d", i), cap_q[i],
                    {tab1[i].data, tab1[i].first, tab1[i].last});
        end
        chk("t1 frame_cnt", frame_cnt, 4);
        do_clear();
        chk("t1 clr frame_cnt", frame_cnt, 0);

        // 2: latency and no frame from 7 samples
        for (int i = 0; i < 7; i++) src_q.push_back(16'(i));
        pv = 100;
        pr = 100;
        run(12);
        chk("t2 no beats from 7", cap_q.size(), 0);
        chk("t2 no m_valid from 7", first_v_cyc, -1);
        src_q.push_back(16'd7);
        run(20);
        // last_acc_cyc is the first cycle in which count has reached 8
        chk("t2 latency", first_v_cyc - last_acc_cyc, 2);
        chk("t2 beats", cap_q.size(), 8);
        if (cap_q.size() == 8) begin
            chk("t2 back-to-back", cap_cyc[7] - cap_cyc[0], 7);
            for (int i = 0; i < 8; i++)
                chk($sformatf("t2 beat %0d", i), cap_q[i],
                    {16'(i), i == 0, i == 7});
        end
        do_clear();

        // 3: stalled sink, buffer fills
        for (int i = 0; i <= 20; i++) src_q.push_back(16'(i));
        pv = 100;
        pr = 0;
        run(30);
        chk("t3 accepts", acc_q.size(), 16);
        chk("t3 s_ready", bus.s_ready, 0);
        chk("t3 m_valid", bus.m_valid, 1);
        chk("t3 m_data", bus.m_data, 0);
        chk("t3 m_first", bus.m_first, 1);
        pr = 100;
        run(60);
        check_model("t3");
        chk("t3 frame_cnt", frame_cnt, 4);
        do_clear();

        // 4: random gaps, full-range values
        over = 1'b0;
        for (int i = 0; i < 1000; i++) begin
            v = 16'($urandom);
            if (i % 97 == 0) v = 16'h8000;
            if (i % 89 == 1) v = 16'h7fff;
            src_q.push_back(v);
        end
        pv = 70;
        pr = 50;
        for (int i = 0; i < 12000; i++) begin
            cycle();
            if (src_q.size() == 0 && cap_q.size() >= 249 * 8) break;
        end
        run(30);
        chk("t4 accepted", acc_q.size(), 1000);
        check_model("t4");
        chk("t4 frame_cnt", frame_cnt, 249);
        chk("t4 count<=16", over, 0);
        do_clear();

        // 5: clear mid frame 2
        for (int i = 0; i < 20; i++) src_q.push_back(16'(i));
        pv = 100;
        pr = 100;
        for (int i = 0; i < 100; i++) begin
            cycle();
            if (cap_q.size() >= 11) break;
        end
        chk("t5 reached 11 beats", cap_q.size(), 11);
        chk("t5 pre frame_cnt", frame_cnt, 1);
        do_clear();
        chk("t5 m_valid after clear", bus.m_valid, 0);
        chk("t5 frame_cnt after clear", frame_cnt, 0);
        for (int i = 0; i < 8; i++) src_q.push_back(16'(100 + i));
        pv = 100;
        pr = 100;
        run(30);
        chk("t5 beats", cap_q.size(), 8);
        for (int i = 0; i < 8; i++) begin
            if (i < cap_q.size())
                chk($sformatf("t5 beat %0d", i), cap_q[i],
                    {16'(100 + i), i == 0, i == 7});
        end
        chk("t5 frame_cnt", frame_cnt, 1);
        do_clear();

        // 6: async reset mid frame
        for (int i = 0; i < 20; i++) src_q.push_back(16'(i + 1));
        pv = 100;
        pr = 100;
        for (int i = 0; i < 100; i++) begin
            cycle();
            if (cap_q.size() >= 11) break;
        end
        chk("t6 pre m_valid", bus.m_valid, 1);
        chk("t6 pre frame_cnt", frame_cnt, 1);
        bus.s_valid = 1'b0;
        bus.m_ready = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        chk("t6 rst m_valid", bus.m_valid, 0);
        chk("t6 rst m_data", bus.m_data, 0);
        chk("t6 rst m_first", bus.m_first, 0);
        chk("t6 rst m_last", bus.m_last, 0);
        chk("t6 rst s_ready", bus.s_ready, 0);
        chk("t6 rst frame_cnt", frame_cnt, 0);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        flush_q();
        for (int i = 0; i < 8; i++) src_q.push_back(16'(50 + i));
        run(30);
        chk("t6 beats", cap_q.size(), 8);
        for (int i = 0; i < 8; i++) begin
            if (i < cap_q.size())
                chk($sformatf("t6 beat %0d", i), cap_q[i],
                    {16'(50 + i), i == 0, i == 7});
        end
        pv = 0;
        pr = 0;

        // 7: default parameters, 2000-sample ramp
        fi = 0;
        st = 0;
        off = 0;
        bad2 = 0;
        done2 = 0;
        n2 = 0;
        tail = 0;
        for (int c = 0; c < 8000; c++) begin
            bus2.s_valid = (n2 < 2000);
            bus2.s_data = 16'(n2);
            bus2.m_ready = 1'b1;
            @(negedge clk);
            if (bus2.s_valid && bus2.s_ready) n2++;
            if (bus2.m_valid && bus2.m_ready) begin
                if (bus2.m_first) begin
                    chk($sformatf("t7 frame %0d start", fi),
                        bus2.m_data, 160 * fi);
                    st = 160 * fi;
                    off = 0;
                    fi++;
                end else begin
                    off++;
                end
                if (bus2.m_data !== 16'(st + off)) bad2++;
                if (bus2.m_last !== (off == 399)) bad2++;
                if (bus2.m_last) done2++;
            end
            @(posedge clk);
            #1;
            if (done2 >= 11) tail++;
            if (tail > 20) break;
        end
        bus2.s_valid = 1'b0;
        chk("t7 accepted", n2, 2000);
        chk("t7 frames started", fi, 11);
        chk("t7 frames done", done2, 11);
        chk("t7 beat errors", bad2, 0);
        chk("t7 frame_cnt", frame_cnt2, 11);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end
endmodule
